// File: rtl/udp_stream_arbiter_pkg.sv
// Shared definitions for the UDP stream arbiter: FSM encoding and width helpers.
package udp_stream_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY  = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_e;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

  // Index width for a source count; never narrower than one bit.
  function automatic int id_width(input int n_src);
    return (clog2(n_src) < 1) ? 1 : clog2(n_src);
  endfunction

endpackage

// File: rtl/udp_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module udp_stream_arbiter_rr_pick #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_SRC-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             gnt_valid
);

  // Scan offsets from farthest to nearest so the nearest requester after last_grant wins.
  always_comb begin
    gnt_idx   = {ID_W{1'b0}};
    gnt_valid = 1'b0;
    for (int k = N_SRC; k >= 1; k--) begin
      logic [ID_W-1:0] cand;
      cand = ID_W'((int'(last_grant) + k) % N_SRC);
      if (req[cand]) begin
        gnt_idx   = cand;
        gnt_valid = 1'b1;
      end else begin
        gnt_idx   = gnt_idx;
        gnt_valid = gnt_valid;
      end
    end
  end

endmodule

// File: rtl/udp_stream_arbiter.sv
// Packet-atomic round-robin merge of N_SRC AXI-Stream sources into one tagged stream,
// with truncation of runaway packets longer than MAX_BEATS.
module udp_stream_arbiter
  import udp_stream_arbiter_pkg::*;
#(
  parameter int N_SRC     = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 1500,
  localparam int ID_W     = id_width(N_SRC)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_SRC*DATA_W-1:0] s_axis_tdata,
  input  logic [N_SRC-1:0]        s_axis_tvalid,
  input  logic [N_SRC-1:0]        s_axis_tlast,
  output logic [N_SRC-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]       m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  output logic [ID_W-1:0]         m_axis_tid,
  input  logic                    m_axis_tready,
  output logic                    trunc_pulse
);

  localparam int CNT_W = clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  arb_state_e        state_r, state_s;
  logic [ID_W-1:0]   grant_r, grant_s;
  logic [ID_W-1:0]   last_grant_r, last_grant_s;
  logic [CNT_W-1:0]  beat_cnt_r, beat_cnt_s;
  logic [CNT_W-1:0]  cnt_inc_s;
  logic [ID_W-1:0]   pick_idx_s;
  logic              pick_valid_s;
  logic              out_free_s;
  logic              sel_valid_s;
  logic              sel_last_s;
  logic [DATA_W-1:0] sel_data_s;
  logic              load_s;
  logic              load_last_s;
  logic              trunc_s;

  udp_stream_arbiter_rr_pick #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_pick (
    .req        (s_axis_tvalid),
    .last_grant (last_grant_r),
    .gnt_idx    (pick_idx_s),
    .gnt_valid  (pick_valid_s)
  );

  // Select the granted source and decide whether the output register can take a beat.
  always_comb begin
    sel_data_s  = s_axis_tdata[int'(grant_r)*DATA_W +: DATA_W];
    sel_valid_s = s_axis_tvalid[grant_r];
    sel_last_s  = s_axis_tlast[grant_r];
    out_free_s  = !m_axis_tvalid || m_axis_tready;
    cnt_inc_s   = beat_cnt_r + CNT_W'(1);
  end

  // Next-state, grant bookkeeping and per-source ready.
  always_comb begin
    state_s       = state_r;
    grant_s       = grant_r;
    last_grant_s  = last_grant_r;
    beat_cnt_s    = beat_cnt_r;
    load_s        = 1'b0;
    load_last_s   = 1'b0;
    trunc_s       = 1'b0;
    s_axis_tready = {N_SRC{1'b0}};
    case (state_r)
      ARB_IDLE: begin
        if (pick_valid_s) begin
          grant_s = pick_idx_s;
          state_s = ARB_BUSY;
        end else begin
          state_s = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        s_axis_tready[grant_r] = out_free_s;
        if (sel_valid_s && out_free_s) begin
          load_s = 1'b1;
          if (sel_last_s) begin
            load_last_s  = 1'b1;
            beat_cnt_s   = {CNT_W{1'b0}};
            last_grant_s = grant_r;
            state_s      = ARB_IDLE;
          end else if (cnt_inc_s == MAX_CNT) begin
            // Runaway packet: close it here, swallow the rest in DRAIN.
            load_last_s  = 1'b1;
            trunc_s      = 1'b1;
            beat_cnt_s   = cnt_inc_s;
            last_grant_s = grant_r;
            state_s      = ARB_DRAIN;
          end else begin
            beat_cnt_s = cnt_inc_s;
          end
        end else begin
          state_s = ARB_BUSY;
        end
      end
      ARB_DRAIN: begin
        s_axis_tready[grant_r] = 1'b1;
        if (sel_valid_s && sel_last_s) begin
          beat_cnt_s = {CNT_W{1'b0}};
          state_s    = ARB_IDLE;
        end else begin
          state_s = ARB_DRAIN;
        end
      end
      default: begin
        beat_cnt_s = {CNT_W{1'b0}};
        state_s    = ARB_IDLE;
      end
    endcase
  end

  // FSM state, grant and beat counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ARB_IDLE;
      grant_r      <= {ID_W{1'b0}};
      last_grant_r <= ID_W'(N_SRC - 1);
      beat_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r      <= state_s;
      grant_r      <= grant_s;
      last_grant_r <= last_grant_s;
      beat_cnt_r   <= beat_cnt_s;
    end
  end

  // Output register: load on accepted beat, hold while stalled, drop valid after handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tdata  <= {DATA_W{1'b0}};
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= {ID_W{1'b0}};
      trunc_pulse   <= 1'b0;
    end else begin
      trunc_pulse <= trunc_s;
      if (load_s) begin
        m_axis_tdata  <= sel_data_s;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= load_last_s;
        m_axis_tid    <= grant_r;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_udp_stream_arbiter.sv
// Scoreboard bench for udp_stream_arbiter (N_SRC=4, DATA_W=32, MAX_BEATS=8).
module tb_udp_stream_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N-1:0]  s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready, trunc_pulse;
  logic [1:0]    m_axis_tid;

  always #5 clk = ~clk;

  udp_stream_arbiter #(.N_SRC(N), .DATA_W(DW), .MAX_BEATS(MB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
    .m_axis_tready (m_axis_tready),
    .trunc_pulse   (trunc_pulse)
  );

  // Per-source beat stores (head/tail indices) and the output scoreboard.
  logic [DW-1:0] sd [N][64];
  logic          sl [N][64];
  int            hd [N];
  int            tl [N];
  logic [N-1:0]  hs;
  logic [34:0]   exp_q [$];
  int            out_cyc [$];
  int            n_cmp, n_err, cyc, trunc_cnt, stall_cnt, rdy_mode;
  logic          prev_stall;
  logic [35:0]   prev_out;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input int src, input int pkt, input int b);
    return {8'hA0, 8'(src), 8'(pkt), 8'(b)};
  endfunction

  task automatic push_src(input int src, input int n, input int pkt);
    for (int b = 0; b < n; b++) begin
      sd[src][tl[src]] = beat_data(src, pkt, b);
      sl[src][tl[src]] = (b == n - 1);
      tl[src]++;
    end
  endtask

  // Expected output of one packet: truncated to MB beats with tlast forced on the final one.
  task automatic expect_pkt(input int src, input int n, input int pkt);
    int m;
    m = (n > MB) ? MB : n;
    for (int b = 0; b < m; b++)
      exp_q.push_back({2'(src), (b == m - 1), beat_data(src, pkt, b)});
  endtask

  function automatic bit src_busy();
    for (int i = 0; i < N; i++)
      if (hd[i] < tl[i]) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: drive at negedge, settle, then sample handshakes and outputs.
  task automatic step();
    logic [34:0] e;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++)
      if (hs[i]) hd[i]++;
    for (int i = 0; i < N; i++) begin
      if (hd[i] < tl[i]) begin
        s_axis_tvalid[i] = 1'b1;
        s_axis_tdata[i*DW +: DW] = sd[i][hd[i]];
        s_axis_tlast[i] = sl[i][hd[i]];
      end else begin
        s_axis_tvalid[i] = 1'b0;
        s_axis_tdata[i*DW +: DW] = {DW{1'b0}};
        s_axis_tlast[i] = 1'b0;
      end
    end
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = 1'(cyc % 2);
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
    #1;
    hs = s_axis_tvalid & s_axis_tready;
    chk("rdy_onehot", 64'($countones(s_axis_tready) <= 1), 64'd1);
    if (prev_stall) begin
      stall_cnt++;
      chk("held", {m_axis_tvalid, m_axis_tid, m_axis_tlast, m_axis_tdata}, prev_out);
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_out   = {m_axis_tvalid, m_axis_tid, m_axis_tlast, m_axis_tdata};
    if (prev_stall) chk("stall_rdy", s_axis_tready, 64'd0);
    if (m_axis_tvalid && m_axis_tready) begin
      out_cyc.push_back(cyc);
      chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat", {m_axis_tid, m_axis_tlast, m_axis_tdata}, e);
      end
    end
    if (trunc_pulse) trunc_cnt++;
  endtask

  task automatic run_until_empty(input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || src_busy()) && n < limit) begin
      step();
      n++;
    end
    chk("timeout", 64'(n < limit), 64'd1);
    repeat (3) step();
  endtask

  initial begin
    int t0, tc0, n;
    s_axis_tdata = {N*DW{1'b0}};
    s_axis_tvalid = {N{1'b0}};
    s_axis_tlast = {N{1'b0}};
    m_axis_tready = 1'b1;
    hs = {N{1'b0}};
    rdy_mode = 0;
    prev_stall = 1'b0;
    for (int i = 0; i < N; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end

    // Reset state
    repeat (2) step();
    chk("rst_outs", {s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tid, m_axis_tdata, trunc_pulse}, 64'd0);
    rst_n = 1'b1;
    step();

    // 1: single 3-beat packet, one arbitration cycle then back-to-back beats
    t0 = cyc;
    out_cyc.delete();
    push_src(0, 3, 1);
    expect_pkt(0, 3, 1);
    run_until_empty(50);
    chk("t1_nbeats", 64'(out_cyc.size()), 64'd3);
    if (out_cyc.size() >= 3) begin
      chk("t1_first", 64'(out_cyc[0]), 64'(t0 + 3));
      chk("t1_third", 64'(out_cyc[2]), 64'(t0 + 5));
    end

    // 2: all sources busy; src0 served last in test 1, so rotation starts at src1
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < N; s++) push_src(s, 2, 10 + p);
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < N; k++) expect_pkt((k + 1) % N, 2, 10 + p);
    run_until_empty(200);

    // 3: alternating downstream backpressure during a 5-beat packet
    rdy_mode = 1;
    stall_cnt = 0;
    push_src(1, 5, 20);
    expect_pkt(1, 5, 20);
    run_until_empty(100);
    chk("t3_stalls", 64'(stall_cnt > 0), 64'd1);
    rdy_mode = 0;

    // 4: 12-beat runaway from src2 truncated to 8; src3 then src0 follow
    tc0 = trunc_cnt;
    push_src(2, 12, 30);
    expect_pkt(2, 12, 30);
    repeat (3) step();
    push_src(3, 2, 31);
    push_src(0, 2, 32);
    expect_pkt(3, 2, 31);
    expect_pkt(0, 2, 32);
    run_until_empty(100);
    chk("t4_trunc", 64'(trunc_cnt - tc0), 64'd1);

    // 5: exactly MB beats with tlast on the last is not truncated
    tc0 = trunc_cnt;
    push_src(1, MB, 40);
    expect_pkt(1, MB, 40);
    run_until_empty(100);
    chk("t5_trunc", 64'(trunc_cnt - tc0), 64'd0);

    // 6: reset in the middle of a 5-beat packet, then src0 must win first
    rdy_mode = 2;
    push_src(0, 5, 50);
    expect_pkt(0, 5, 50);
    n = 0;
    while (exp_q.size() > 3 && n < 50) begin
      step();
      n++;
    end
    chk("t6_reach", 64'(n < 50), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", {s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tid, m_axis_tdata, trunc_pulse}, 64'd0);
    exp_q.delete();
    for (int i = 0; i < N; i++) hd[i] = tl[i];
    hs = {N{1'b0}};
    prev_stall = 1'b0;
    rdy_mode = 0;
    repeat (2) step();
    rst_n = 1'b1;
    push_src(1, 2, 60);
    push_src(0, 2, 61);
    expect_pkt(0, 2, 61);
    expect_pkt(1, 2, 60);
    run_until_empty(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
